// File: rtl/front_dispatch_buffer_pkg.sv
// Shared types for the front-end dispatch buffer: IQueue entry, dispatch lane and batch.
// No logic; types and constants only.
// Imported by the interface, the batch FIFO and the top level.
package front_dispatch_buffer_pkg;

  // Default lane count of a dispatch batch (rename ILN width).
  localparam int DISPATCH_LANES      = 4;
  localparam int NUM_EXEC_UNITS      = 4;
  localparam int LOG2_NUM_EXEC_UNITS = $clog2(NUM_EXEC_UNITS);

  // One renamed instruction as it sits in an EU issue queue.
  typedef struct packed {
    logic [15:0] pc;
    logic [7:0]  opcode;
  } type_iqueue_entry;

  // One lane of a dispatch batch: instruction, lane valid and allocated EU.
  typedef struct packed {
    type_iqueue_entry                 entry;
    logic                             valid;
    logic [LOG2_NUM_EXEC_UNITS-1:0]   euidx;
  } type_dispatch_lane;

  // A full batch at the default lane count.
  typedef type_dispatch_lane [DISPATCH_LANES-1:0] type_dispatch_batch;

  // Storage width of a batch with the given number of lanes.
  function automatic int batch_bits(input int lanes);
    return lanes * $bits(type_dispatch_lane);
  endfunction

endpackage

// File: rtl/front_dispatch_buffer_if.sv
// Batch handshake between allocation (master) and the dispatch buffer (slave),
// plus the dispatch bus the buffer drives towards the backend.
// Pure wiring; no storage and no latency of its own.
interface front_dispatch_buffer_if
  import front_dispatch_buffer_pkg::*;
#(
  parameter int N = DISPATCH_LANES
);

  // Upstream batch offer.
  logic                                   batch_push_i;
  type_iqueue_entry [N-1:0]               batch_i;
  logic [N-1:0]                           batch_valid_i;
  logic [N-1:0][LOG2_NUM_EXEC_UNITS-1:0]  batch_euidx_i;
  logic                                   batch_ready_o;

  // Backend dispatch bus.
  type_iqueue_entry [N-1:0]               instr_dispatch_o;
  logic [N-1:0]                           instr_dispatch_valid_o;
  logic [N-1:0][LOG2_NUM_EXEC_UNITS-1:0]  dispatched_instr_alloc_euidx_o;
  logic                                   instr_dispatch_ready_i;

  // Buffer side.
  modport slave (
    input  batch_push_i, batch_i, batch_valid_i, batch_euidx_i, instr_dispatch_ready_i,
    output batch_ready_o, instr_dispatch_o, instr_dispatch_valid_o,
    dispatched_instr_alloc_euidx_o
  );

  // Allocation / backend side.
  modport master (
    output batch_push_i, batch_i, batch_valid_i, batch_euidx_i, instr_dispatch_ready_i,
    input  batch_ready_o, instr_dispatch_o, instr_dispatch_valid_o,
    dispatched_instr_alloc_euidx_o
  );

endinterface

// File: rtl/front_dispatch_batch_fifo.sv
// Generic WIDTH x DEPTH FIFO with count and synchronous flush; head is a combinational read.
// Latency: a push is visible at head one cycle later when the FIFO was empty.
// Backpressure: pushes while full are ignored, pops while empty are ignored; flush wins over both.
module front_dispatch_batch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_dat_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             head_dat_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  // Storage is deliberately left out of reset; the count alone says what is live.
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  // Next-state for pointers and count; pointers wrap naturally at DEPTH (power of two).
  always_comb begin
    push_ok  = push_i & (count_q != CNT_W'(DEPTH)) & ~flush_i;
    pop_ok   = pop_i & (count_q != '0) & ~flush_i;
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    count_d  = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CNT_W'(1);
    end
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // Pointer and count state; reset clears them immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Batch storage write at the tail.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  assign head_dat_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/front_dispatch_buffer.sv
// Batch FIFO between EU allocation and the backend dispatch bus; presents the oldest batch.
// Latency: 1 cycle push-to-dispatch when empty (0 with DISPATCH_BUF_BYPASS_EN defined).
// Backpressure: batch_ready_o = not full, from registered state only; pop on instr_dispatch_ready_i.
module front_dispatch_buffer
  import front_dispatch_buffer_pkg::*;
#(
  parameter int NUM_PARALLEL_INSTR_DISPATCHES = 4,
  parameter int DEPTH                         = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          flush_i,
  front_dispatch_buffer_if.slave        disp_if,
  output logic [$clog2(DEPTH+1)-1:0]    occupancy_o
);

  localparam int N     = NUM_PARALLEL_INSTR_DISPATCHES;
  localparam int WIDTH = batch_bits(N);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef type_dispatch_lane [N-1:0] lanes_t;

  lanes_t           in_lanes;
  lanes_t           head_lanes;
  lanes_t           out_lanes;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             push_fire;
  logic             pop_fire;
  logic             fifo_push;

  // Gather the per-lane input vectors into one batch word for storage.
  always_comb begin
    in_lanes = '0;
    for (int i = 0; i < N; i++) begin
      in_lanes[i].entry = disp_if.batch_i[i];
      in_lanes[i].valid = disp_if.batch_valid_i[i];
      in_lanes[i].euidx = disp_if.batch_euidx_i[i];
    end
  end

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

  // Ready looks only at the stored count, so a same-cycle pop never frees a full queue.
  assign disp_if.batch_ready_o = ~full;

  // An all-invalid batch carries nothing, so it is dropped rather than stored.
  assign push_fire = disp_if.batch_push_i & ~full & ~flush_i & (|disp_if.batch_valid_i);
  assign pop_fire  = ~empty & disp_if.instr_dispatch_ready_i & ~flush_i;

`ifdef DISPATCH_BUF_BYPASS_EN
  logic bypass_fire;

  // An empty queue hands a fresh batch straight to the outputs; if the backend takes it
  // in the same cycle it is never written.
  assign bypass_fire = empty & push_fire;
  assign fifo_push   = push_fire & ~(bypass_fire & disp_if.instr_dispatch_ready_i);

  // Output select: bypassed batch, stored head, or all-zero when empty.
  always_comb begin
    out_lanes = '0;
    if (bypass_fire) begin
      out_lanes = in_lanes;
    end else if (!empty) begin
      out_lanes = head_lanes;
    end
  end
`else
  assign fifo_push = push_fire;

  // Output select: stored head, or all-zero when empty.
  always_comb begin
    out_lanes = '0;
    if (!empty) begin
      out_lanes = head_lanes;
    end
  end
`endif

  front_dispatch_batch_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush_i    (flush_i),
    .push_i     (fifo_push),
    .push_dat_i (in_lanes),
    .pop_i      (pop_fire),
    .head_dat_o (head_lanes),
    .count_o    (count)
  );

  // Scatter the selected batch back onto the dispatch bus.
  always_comb begin
    disp_if.instr_dispatch_o               = '0;
    disp_if.instr_dispatch_valid_o         = '0;
    disp_if.dispatched_instr_alloc_euidx_o = '0;
    for (int i = 0; i < N; i++) begin
      disp_if.instr_dispatch_o[i]               = out_lanes[i].entry;
      disp_if.instr_dispatch_valid_o[i]         = out_lanes[i].valid;
      disp_if.dispatched_instr_alloc_euidx_o[i] = out_lanes[i].euidx;
    end
  end

  assign occupancy_o = count;

endmodule

// File: tb/tb_front_dispatch_buffer.sv
// Self-checking bench for front_dispatch_buffer: directed vector table, reset/bypass
// sequences and a randomized run against a queue-based reference model.
// Works with and without DISPATCH_BUF_BYPASS_EN defined.
module tb_front_dispatch_buffer;
  import front_dispatch_buffer_pkg::*;

  localparam int N     = 4;
  localparam int DEPTH = 4;

`ifdef DISPATCH_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef type_iqueue_entry [N-1:0]  data_t;
  typedef logic [N-1:0][1:0]         eu_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       flush_i;
  logic [2:0] occ;

  int errors = 0;
  int checks = 0;

  front_dispatch_buffer_if #(.N(N)) dif ();

  front_dispatch_buffer #(
    .NUM_PARALLEL_INSTR_DISPATCHES (N),
    .DEPTH                         (DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flush_i     (flush_i),
    .disp_if     (dif),
    .occupancy_o (occ)
  );

  always #5 clk = ~clk;

  // Payload and EU index are derived from a batch tag so every batch is distinguishable.
  function automatic data_t mk_data(input logic [7:0] tag);
    data_t d;
    for (int l = 0; l < N; l++) begin
      d[l].pc     = {tag, 8'(l)};
      d[l].opcode = tag ^ 8'hA5;
    end
    return d;
  endfunction

  function automatic eu_t mk_eu(input logic [7:0] tag);
    eu_t e;
    for (int l = 0; l < N; l++) e[l] = 2'(tag + 8'(l));
    return e;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit push, input logic [3:0] vld, input logic [7:0] tag,
                       input bit rdy, input bit flush);
    dif.batch_push_i           = push;
    dif.batch_valid_i          = vld;
    dif.batch_i                = mk_data(tag);
    dif.batch_euidx_i          = mk_eu(tag);
    dif.instr_dispatch_ready_i = rdy;
    flush_i                    = flush;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
  endtask

  // Compare every output against an expected head (tag + lane valids) and occupancy.
  task automatic check_out(input string pfx, input int e_occ, input logic [3:0] e_vld,
                           input logic [7:0] e_tag, input bit e_brdy);
    data_t e_d;
    eu_t   e_e;
    e_d = (e_vld != 4'h0) ? mk_data(e_tag) : data_t'(0);
    e_e = (e_vld != 4'h0) ? mk_eu(e_tag)   : eu_t'(0);
    check({pfx, ".occ"},   128'(occ),                              128'(e_occ));
    check({pfx, ".valid"}, 128'(dif.instr_dispatch_valid_o),       128'(e_vld));
    check({pfx, ".data"},  128'(dif.instr_dispatch_o),             128'(e_d));
    check({pfx, ".euidx"}, 128'(dif.dispatched_instr_alloc_euidx_o), 128'(e_e));
    check({pfx, ".brdy"},  128'(dif.batch_ready_o),                128'(e_brdy));
  endtask

  // One clocked step: apply inputs across a rising edge, then return to idle.
  task automatic step(input bit push, input logic [3:0] vld, input logic [7:0] tag,
                      input bit rdy, input bit flush);
    @(negedge clk);
    drive(push, vld, tag, rdy, flush);
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  typedef struct {
    bit         push;
    logic [3:0] vld;
    logic [7:0] tag;
    bit         rdy;
    bit         flush;
    int         e_occ;
    logic [3:0] e_vld;
    logic [7:0] e_tag;
    bit         e_brdy;
  } vec_t;

  function automatic vec_t v(input bit push, input logic [3:0] vld, input logic [7:0] tag,
                             input bit rdy, input bit flush, input int e_occ,
                             input logic [3:0] e_vld, input logic [7:0] e_tag, input bit e_brdy);
    vec_t r;
    r.push = push; r.vld = vld; r.tag = tag; r.rdy = rdy; r.flush = flush;
    r.e_occ = e_occ; r.e_vld = e_vld; r.e_tag = e_tag; r.e_brdy = e_brdy;
    return r;
  endfunction

  typedef struct {
    logic [7:0] tag;
    logic [3:0] vld;
  } mbatch_t;

  vec_t    tv[31];
  mbatch_t mq[$];

  initial begin
    // Directed vectors; expected values are the state after the clock edge, inputs idle.
    tv[0]  = v(1, 4'b0101,  1, 0, 0, 1, 4'b0101,  1, 1); // A: lanes 0,2, euidx 1,3
    tv[1]  = v(0, 4'h0,     0, 1, 0, 0, 4'h0,     0, 1); // pop A
    tv[2]  = v(1, 4'hF,     2, 0, 0, 1, 4'hF,     2, 1);
    tv[3]  = v(1, 4'hF,     3, 0, 0, 2, 4'hF,     2, 1);
    tv[4]  = v(1, 4'hF,     4, 0, 0, 3, 4'hF,     2, 1);
    tv[5]  = v(1, 4'hF,     5, 0, 0, 4, 4'hF,     2, 0); // full
    tv[6]  = v(1, 4'hF,     6, 0, 0, 4, 4'hF,     2, 0); // 5th push ignored
    tv[7]  = v(0, 4'h0,     0, 1, 0, 3, 4'hF,     3, 1);
    tv[8]  = v(0, 4'h0,     0, 1, 0, 2, 4'hF,     4, 1);
    tv[9]  = v(0, 4'h0,     0, 1, 0, 1, 4'hF,     5, 1);
    tv[10] = v(0, 4'h0,     0, 1, 0, 0, 4'h0,     0, 1);
    tv[11] = v(1, 4'hF,     7, 0, 0, 1, 4'hF,     7, 1);
    tv[12] = v(1, 4'hF,     8, 0, 0, 2, 4'hF,     7, 1);
    tv[13] = v(1, 4'hF,     9, 0, 0, 3, 4'hF,     7, 1);
    tv[14] = v(1, 4'hF,    10, 0, 0, 4, 4'hF,     7, 0);
    tv[15] = v(1, 4'hF,    11, 1, 0, 3, 4'hF,     8, 1); // full: push+pop -> pop only
    tv[16] = v(0, 4'h0,     0, 1, 0, 2, 4'hF,     9, 1);
    tv[17] = v(1, 4'hF,    12, 1, 0, 2, 4'hF,    10, 1); // push+pop at occ 2
    tv[18] = v(1, 4'b0011, 13, 1, 0, 2, 4'hF,    12, 1);
    tv[19] = v(1, 4'hF,    14, 1, 0, 2, 4'b0011, 13, 1);
    tv[20] = v(1, 4'hF,    15, 1, 0, 2, 4'hF,    14, 1);
    tv[21] = v(1, 4'hF,    16, 1, 0, 2, 4'hF,    15, 1);
    tv[22] = v(0, 4'h0,     0, 1, 0, 1, 4'hF,    16, 1);
    tv[23] = v(0, 4'h0,     0, 1, 0, 0, 4'h0,     0, 1);
    tv[24] = v(1, 4'h0,    17, 0, 0, 0, 4'h0,     0, 1); // all-invalid push dropped
    tv[25] = v(1, 4'hF,    18, 0, 0, 1, 4'hF,    18, 1);
    tv[26] = v(1, 4'hF,    19, 0, 0, 2, 4'hF,    18, 1);
    tv[27] = v(1, 4'hF,    20, 0, 0, 3, 4'hF,    18, 1);
    tv[28] = v(1, 4'hF,    21, 0, 1, 0, 4'h0,     0, 1); // flush beats push
    tv[29] = v(1, 4'b0110, 22, 0, 0, 1, 4'b0110, 22, 1);
    tv[30] = v(0, 4'h0,     0, 1, 0, 0, 4'h0,     0, 1);

    reset_n = 1'b0;
    idle();
    #1;
    check_out("reset", 0, 4'h0, 8'h0, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 31; i++) begin
      step(tv[i].push, tv[i].vld, tv[i].tag, tv[i].rdy, tv[i].flush);
      check_out($sformatf("vec%0d", i), tv[i].e_occ, tv[i].e_vld, tv[i].e_tag, tv[i].e_brdy);
    end

    // Asynchronous reset in the middle of a cycle with three batches stored.
    step(1, 4'hF, 30, 0, 0);
    step(1, 4'hF, 31, 0, 0);
    step(1, 4'hF, 32, 0, 0);
    check_out("pre_rst", 3, 4'hF, 30, 1'b1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_out("mid_rst", 0, 4'h0, 8'h0, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_out("post_rst", 0, 4'h0, 8'h0, 1'b1);

`ifdef DISPATCH_BUF_BYPASS_EN
    // Bypass from empty: consumed in the same cycle, then held when backend stalls.
    @(negedge clk);
    drive(1, 4'hF, 40, 1, 0);
    #1;
    check_out("byp_b_same", 0, 4'hF, 40, 1'b1);
    @(posedge clk);
    #1;
    idle();
    #1;
    check_out("byp_b_after", 0, 4'h0, 8'h0, 1'b1);
    @(negedge clk);
    drive(1, 4'hF, 41, 0, 0);
    #1;
    check_out("byp_c_same", 0, 4'hF, 41, 1'b1);
    @(posedge clk);
    #1;
    idle();
    #1;
    check_out("byp_c_held", 1, 4'hF, 41, 1'b1);
    step(0, 4'h0, 0, 1, 0);
`endif

    // Randomized run against a queue model; start from a known-empty queue.
    step(0, 4'h0, 0, 0, 1);
    mq.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit         r_push, r_rdy, r_flush, m_push, m_pop, m_byp;
      logic [3:0] r_vld;
      logic [7:0] r_tag;
      logic [3:0] e_vld;
      logic [7:0] e_tag;
      r_push  = ($urandom_range(0, 99) < 65);
      r_vld   = ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom);
      r_tag   = 8'($urandom);
      r_rdy   = ($urandom_range(0, 99) < 45);
      r_flush = ($urandom_range(0, 99) < 3);
      @(negedge clk);
      drive(r_push, r_vld, r_tag, r_rdy, r_flush);
      m_push = r_push && (mq.size() < DEPTH) && !r_flush && (r_vld != 4'h0);
      m_pop  = (mq.size() != 0) && r_rdy && !r_flush;
      m_byp  = BYP && (mq.size() == 0) && m_push;
      if (mq.size() != 0) begin
        e_vld = mq[0].vld;
        e_tag = mq[0].tag;
      end else if (m_byp) begin
        e_vld = r_vld;
        e_tag = r_tag;
      end else begin
        e_vld = 4'h0;
        e_tag = 8'h0;
      end
      #1;
      // Model outputs only with non-zero valids; a bypassed all-zero batch cannot occur.
      check_out($sformatf("rnd%0d", cyc), mq.size(), e_vld, e_tag, mq.size() < DEPTH);
      @(posedge clk);
      if (r_flush) begin
        mq.delete();
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (m_push && !(m_byp && r_rdy)) mq.push_back('{tag: r_tag, vld: r_vld});
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
